// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS controller.
// Holds ALU operation codes, opcode/funct values, the controller state enum,
// the decoded instruction class and the datapath mux encodings.
package mips_pkg;

  // ALU operation codes driven on alu_control
  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluAddi = 4'b0001;
  localparam logic [3:0] AluLw   = 4'b0010;
  localparam logic [3:0] AluSw   = 4'b0011;
  localparam logic [3:0] AluSll  = 4'b0100;
  localparam logic [3:0] AluAnd  = 4'b0101;
  localparam logic [3:0] AluAndi = 4'b0110;
  localparam logic [3:0] AluNor  = 4'b0111;
  localparam logic [3:0] AluBeq  = 4'b1000;
  localparam logic [3:0] AluJal  = 4'b1001;
  localparam logic [3:0] AluJr   = 4'b1010;
  localparam logic [3:0] AluSlt  = 4'b1011;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJal   = 6'b000011;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSll = 6'b000000;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnNor = 6'b100111;
  localparam logic [5:0] FnSlt = 6'b101010;
  localparam logic [5:0] FnJr  = 6'b001000;

  // reg_dst encodings
  localparam logic [1:0] RegDstRt = 2'd0;
  localparam logic [1:0] RegDstRd = 2'd1;
  localparam logic [1:0] RegDst31 = 2'd2;

  // mem_to_reg encodings
  localparam logic [1:0] MemToRegAlu = 2'd0;
  localparam logic [1:0] MemToRegMem = 2'd1;
  localparam logic [1:0] MemToRegPc  = 2'd2;

  // alu_src_b encodings
  localparam logic [1:0] AluBRt   = 2'd0;
  localparam logic [1:0] AluB4    = 2'd1;
  localparam logic [1:0] AluBSext = 2'd2;
  localparam logic [1:0] AluBZext = 2'd3;

  // pc_src encodings
  localparam logic [1:0] PcSrcAlu    = 2'd0;
  localparam logic [1:0] PcSrcBranch = 2'd1;
  localparam logic [1:0] PcSrcJump   = 2'd2;
  localparam logic [1:0] PcSrcRs     = 2'd3;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecR,
    StWbR,
    StExecI,
    StWbI,
    StMemAddr,
    StMemRd,
    StMemWb,
    StMemWr,
    StBranch,
    StJal,
    StJr
  } state_e;

  typedef enum logic [2:0] {
    ClsR,
    ClsI,
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsJal,
    ClsJr
  } instr_class_e;

endpackage

// File: rtl/mips_alu_decode.sv
// Combinational instruction decoder.
// Ports:
//   opcode   in  6  IR[31:26]
//   funct    in  6  IR[5:0]
//   alu_code out 4  ALU operation code for the instruction
//   cls      out    instruction class used by the controller to branch out of DECODE
//   illegal  out 1  instruction is not in the supported set
module mips_alu_decode
  import mips_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output logic [3:0]   alu_code,
  output instr_class_e cls,
  output logic         illegal
);

  always_comb begin
    alu_code = AluAdd;
    cls      = ClsR;
    illegal  = 1'b0;
    case (opcode)
      OpRtype: begin
        case (funct)
          FnAdd:   alu_code = AluAdd;
          FnSll:   alu_code = AluSll;
          FnAnd:   alu_code = AluAnd;
          FnNor:   alu_code = AluNor;
          FnSlt:   alu_code = AluSlt;
          FnJr: begin
            alu_code = AluJr;
            cls      = ClsJr;
          end
          default: illegal = 1'b1;
        endcase
      end
      OpAddi: begin
        alu_code = AluAddi;
        cls      = ClsI;
      end
      OpAndi: begin
        alu_code = AluAndi;
        cls      = ClsI;
      end
      OpLw: begin
        alu_code = AluLw;
        cls      = ClsLoad;
      end
      OpSw: begin
        alu_code = AluSw;
        cls      = ClsStore;
      end
      OpBeq: begin
        alu_code = AluBeq;
        cls      = ClsBranch;
      end
      OpJal: begin
        alu_code = AluJal;
        cls      = ClsJal;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS main controller.
// Sequences each instruction through fetch/decode/execute/memory/write-back,
// drives the ALU operation code and all datapath enables and selects, stalls
// on memory, and counts retired instructions.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   opcode, funct        instruction fields from IR (valid from DECODE on)
//   alu_zero             ALU zero flag, resolves beq
//   mem_ready            memory finishes the current access this cycle
//   alu_control          ALU operation code
//   pc_write, ir_write   PC / IR load enables
//   iord                 memory address select (0 = PC, 1 = ALU)
//   mem_read, mem_write  memory strobes
//   reg_write, reg_dst, mem_to_reg  register-file write controls
//   alu_src_a, alu_src_b ALU operand selects
//   pc_src               next-PC select
//   illegal              one-cycle pulse on an undecodable instruction
//   instr_count          retired instruction count, wraps mod 2^IW
module mips_mc_control
  import mips_pkg::*;
#(
  parameter int unsigned IW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [5:0]    opcode,
  input  logic [5:0]    funct,
  input  logic          alu_zero,
  input  logic          mem_ready,
  output logic [3:0]    alu_control,
  output logic          pc_write,
  output logic          ir_write,
  output logic          iord,
  output logic          mem_read,
  output logic          mem_write,
  output logic          reg_write,
  output logic [1:0]    reg_dst,
  output logic [1:0]    mem_to_reg,
  output logic          alu_src_a,
  output logic [1:0]    alu_src_b,
  output logic [1:0]    pc_src,
  output logic          illegal,
  output logic [IW-1:0] instr_count
);

  localparam logic [IW-1:0] CountOne = {{(IW-1){1'b0}}, 1'b1};

  state_e       state_q, state_d;
  logic [IW-1:0] count_q;
  logic          retire;

  logic [3:0]    dec_code;
  instr_class_e  dec_cls;
  logic          dec_illegal;

  mips_alu_decode u_decode (
    .opcode   (opcode),
    .funct    (funct),
    .alu_code (dec_code),
    .cls      (dec_cls),
    .illegal  (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        count_q <= count_q + CountOne;
      end
    end
  end

  assign instr_count = count_q;

  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    alu_control = AluAdd;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = RegDstRt;
    mem_to_reg  = MemToRegAlu;
    alu_src_a   = 1'b0;
    alu_src_b   = AluBRt;
    pc_src      = PcSrcAlu;
    illegal     = 1'b0;

    case (state_q)
      StIdle: state_d = StFetch;

      StFetch: begin
        // PC + 4 computed alongside the instruction read
        mem_read  = 1'b1;
        alu_src_b = AluB4;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end
      end

      StDecode: begin
        if (dec_illegal) begin
          illegal = 1'b1;
          state_d = StFetch;
        end else begin
          case (dec_cls)
            ClsR:              state_d = StExecR;
            ClsI:              state_d = StExecI;
            ClsLoad, ClsStore: state_d = StMemAddr;
            ClsBranch:         state_d = StBranch;
            ClsJal:            state_d = StJal;
            ClsJr:             state_d = StJr;
            default:           state_d = StFetch;
          endcase
        end
      end

      StExecR, StWbR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = AluBRt;
        alu_control = dec_code;
        if (state_q == StWbR) begin
          reg_write = 1'b1;
          reg_dst   = RegDstRd;
          retire    = 1'b1;
          state_d   = StFetch;
        end else begin
          state_d = StWbR;
        end
      end

      StExecI, StWbI: begin
        alu_src_a   = 1'b1;
        // andi zero-extends its immediate, addi sign-extends
        alu_src_b   = (dec_code == AluAndi) ? AluBZext : AluBSext;
        alu_control = dec_code;
        if (state_q == StWbI) begin
          reg_write = 1'b1;
          reg_dst   = RegDstRt;
          retire    = 1'b1;
          state_d   = StFetch;
        end else begin
          state_d = StWbI;
        end
      end

      StMemAddr: begin
        alu_src_a   = 1'b1;
        alu_src_b   = AluBSext;
        alu_control = dec_code;
        state_d     = (dec_cls == ClsStore) ? StMemWr : StMemRd;
      end

      StMemRd: begin
        // address stays on the ALU output for the whole access
        mem_read    = 1'b1;
        iord        = 1'b1;
        alu_src_a   = 1'b1;
        alu_src_b   = AluBSext;
        alu_control = dec_code;
        if (mem_ready) begin
          state_d = StMemWb;
        end
      end

      StMemWb: begin
        reg_write  = 1'b1;
        reg_dst    = RegDstRt;
        mem_to_reg = MemToRegMem;
        retire     = 1'b1;
        state_d    = StFetch;
      end

      StMemWr: begin
        mem_write   = 1'b1;
        iord        = 1'b1;
        alu_src_a   = 1'b1;
        alu_src_b   = AluBSext;
        alu_control = dec_code;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = StFetch;
        end
      end

      StBranch: begin
        alu_src_a   = 1'b1;
        alu_src_b   = AluBRt;
        alu_control = AluBeq;
        pc_src      = PcSrcBranch;
        // Mealy: the comparison resolves in this same cycle
        pc_write    = alu_zero;
        retire      = 1'b1;
        state_d     = StFetch;
      end

      StJal: begin
        alu_control = AluJal;
        reg_write   = 1'b1;
        reg_dst     = RegDst31;
        mem_to_reg  = MemToRegPc;
        pc_src      = PcSrcJump;
        pc_write    = 1'b1;
        retire      = 1'b1;
        state_d     = StFetch;
      end

      StJr: begin
        alu_control = AluJr;
        pc_src      = PcSrcRs;
        pc_write    = 1'b1;
        retire      = 1'b1;
        state_d     = StFetch;
      end

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Scoreboard bench for mips_mc_control: each instruction enqueues its
// expected per-cycle output vector and count; a driver pops one entry per
// cycle, applies its inputs and compares the DUT outputs.
module tb_mips_mc_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       alu_zero, mem_ready;
  logic [3:0] alu_control;
  logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
  logic       alu_src_a, illegal;
  logic [3:0] instr_count;

  always #5 clk = ~clk;

  mips_mc_control #(.IW(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .funct       (funct),
    .alu_zero    (alu_zero),
    .mem_ready   (mem_ready),
    .alu_control (alu_control),
    .pc_write    (pc_write),
    .ir_write    (ir_write),
    .iord        (iord),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .pc_src      (pc_src),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  logic [19:0] obs;
  assign obs = {alu_control, pc_write, ir_write, iord, mem_read, mem_write, reg_write,
                reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src, illegal};

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        rdy;
    logic        zero;
    logic [19:0] vec;
    logic [3:0]  cnt;
  } cyc_t;

  cyc_t       sb_q[$];
  logic [3:0] exp_cnt;
  logic [5:0] cur_op, cur_fn;
  int         checks = 0;
  int         errors = 0;
  int         cyc_n  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] mk(input logic [3:0] alu, input logic pcw, input logic irw,
                                     input logic io, input logic mr, input logic mw,
                                     input logic rw, input logic [1:0] rd,
                                     input logic [1:0] m2r, input logic sa,
                                     input logic [1:0] sb, input logic [1:0] ps,
                                     input logic ill);
    return {alu, pcw, irw, io, mr, mw, rw, rd, m2r, sa, sb, ps, ill};
  endfunction

  task automatic push(input logic rdy, input logic zero, input logic [19:0] vec);
    cyc_t e;
    e.op   = cur_op;
    e.fn   = cur_fn;
    e.rdy  = rdy;
    e.zero = zero;
    e.vec  = vec;
    e.cnt  = exp_cnt;
    sb_q.push_back(e);
  endtask

  // FETCH (with stalls) followed by a quiet DECODE
  task automatic q_start(input logic [5:0] op, input logic [5:0] fn, input int fstall);
    cur_op = op;
    cur_fn = fn;
    for (int i = 0; i < fstall; i++) push(1'b0, 1'b0, mk(4'h0, 0,0,0,1,0,0, 2'd0, 2'd0, 0, 2'd1, 2'd0, 0));
    push(1'b1, 1'b0, mk(4'h0, 1,1,0,1,0,0, 2'd0, 2'd0, 0, 2'd1, 2'd0, 0));
    push(1'b1, 1'b0, 20'h0);
  endtask

  task automatic q_rtype(input logic [5:0] fn, input logic [3:0] code);
    q_start(6'b000000, fn, 0);
    push(1'b1, 1'b0, mk(code, 0,0,0,0,0,0, 2'd0, 2'd0, 1, 2'd0, 2'd0, 0));
    push(1'b1, 1'b0, mk(code, 0,0,0,0,0,1, 2'd1, 2'd0, 1, 2'd0, 2'd0, 0));
    exp_cnt++;
  endtask

  task automatic q_itype(input logic [5:0] op, input logic [3:0] code, input logic [1:0] sb);
    q_start(op, 6'h2a, 0);
    push(1'b1, 1'b0, mk(code, 0,0,0,0,0,0, 2'd0, 2'd0, 1, sb, 2'd0, 0));
    push(1'b1, 1'b0, mk(code, 0,0,0,0,0,1, 2'd0, 2'd0, 1, sb, 2'd0, 0));
    exp_cnt++;
  endtask

  task automatic q_lw(input int fstall, input int stall);
    q_start(6'b100011, 6'h11, fstall);
    push(1'b1, 1'b0, mk(4'b0010, 0,0,0,0,0,0, 2'd0, 2'd0, 1, 2'd2, 2'd0, 0));
    for (int i = 0; i < stall; i++)
      push(1'b0, 1'b0, mk(4'b0010, 0,0,1,1,0,0, 2'd0, 2'd0, 1, 2'd2, 2'd0, 0));
    push(1'b1, 1'b0, mk(4'b0010, 0,0,1,1,0,0, 2'd0, 2'd0, 1, 2'd2, 2'd0, 0));
    push(1'b1, 1'b0, mk(4'b0000, 0,0,0,0,0,1, 2'd0, 2'd1, 0, 2'd0, 2'd0, 0));
    exp_cnt++;
  endtask

  // sw; when finish is 0 the access is left pending in MEM_WR
  task automatic q_sw(input int stall, input bit finish);
    q_start(6'b101011, 6'h05, 0);
    push(1'b1, 1'b0, mk(4'b0011, 0,0,0,0,0,0, 2'd0, 2'd0, 1, 2'd2, 2'd0, 0));
    for (int i = 0; i < stall; i++)
      push(1'b0, 1'b0, mk(4'b0011, 0,0,1,0,1,0, 2'd0, 2'd0, 1, 2'd2, 2'd0, 0));
    if (finish) begin
      push(1'b1, 1'b0, mk(4'b0011, 0,0,1,0,1,0, 2'd0, 2'd0, 1, 2'd2, 2'd0, 0));
      exp_cnt++;
    end
  endtask

  task automatic q_beq(input logic zero);
    q_start(6'b000100, 6'h00, 0);
    push(1'b1, zero, mk(4'b1000, zero,0,0,0,0,0, 2'd0, 2'd0, 1, 2'd0, 2'd1, 0));
    exp_cnt++;
  endtask

  task automatic q_jal();
    q_start(6'b000011, 6'h00, 0);
    push(1'b1, 1'b0, mk(4'b1001, 1,0,0,0,0,1, 2'd2, 2'd2, 0, 2'd0, 2'd2, 0));
    exp_cnt++;
  endtask

  task automatic q_jr();
    q_start(6'b000000, 6'b001000, 0);
    push(1'b1, 1'b0, mk(4'b1010, 1,0,0,0,0,0, 2'd0, 2'd0, 0, 2'd0, 2'd3, 0));
    exp_cnt++;
  endtask

  task automatic q_illegal(input logic [5:0] op);
    cur_op = op;
    cur_fn = 6'h00;
    push(1'b1, 1'b0, mk(4'h0, 1,1,0,1,0,0, 2'd0, 2'd0, 0, 2'd1, 2'd0, 0));
    push(1'b1, 1'b0, mk(4'h0, 0,0,0,0,0,0, 2'd0, 2'd0, 0, 2'd0, 2'd0, 1));
  endtask

  task automatic drain();
    cyc_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      @(posedge clk);
      #1;
      opcode    = e.op;
      funct     = e.fn;
      mem_ready = e.rdy;
      alu_zero  = e.zero;
      @(negedge clk);
      check_eq($sformatf("out_c%0d_op%02h", cyc_n, e.op), {12'h0, obs}, {12'h0, e.vec});
      check_eq($sformatf("cnt_c%0d", cyc_n), {28'h0, instr_count}, {28'h0, e.cnt});
      cyc_n++;
    end
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_out"}, {12'h0, obs}, 32'h0);
    check_eq({tag, "_cnt"}, {28'h0, instr_count}, 32'h0);
  endtask

  initial begin
    rst_n     = 1'b0;
    opcode    = 6'h0;
    funct     = 6'h0;
    alu_zero  = 1'b0;
    mem_ready = 1'b1;
    exp_cnt   = 4'h0;
    cur_op    = 6'h0;
    cur_fn    = 6'h0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;
    #1;
    check_quiet("idle");

    q_rtype(6'b100000, 4'b0000);           // add
    q_lw(1, 2);                            // lw with fetch and memory stalls
    q_beq(1'b1);
    q_beq(1'b0);
    q_jal();
    q_jr();
    q_illegal(6'b111111);
    q_rtype(6'b000000, 4'b0100);           // sll
    q_rtype(6'b100100, 4'b0101);           // and
    q_rtype(6'b100111, 4'b0111);           // nor
    q_rtype(6'b101010, 4'b1011);           // slt
    q_itype(6'b001000, 4'b0001, 2'd2);     // addi
    q_itype(6'b001100, 4'b0110, 2'd3);     // andi
    q_sw(1, 1'b1);
    q_sw(2, 1'b0);                         // left waiting in MEM_WR
    drain();

    // asynchronous reset in the middle of a stalled store
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet("midreset");
    @(negedge clk);
    rst_n   = 1'b1;
    exp_cnt = 4'h0;
    #1;
    check_quiet("idle2");

    // 16 retires on a 4-bit counter wrap back to zero
    for (int i = 0; i < 16; i++) q_jr();
    q_illegal(6'b111110);
    drain();
    check_eq("wrap", {28'h0, instr_count}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Multi-cycle main controller for the MIPS core: sequences each instruction through fetch, decode, execute, memory and write-back states and drives the 4-bit `alu_control` code plus all datapath enables/selects. It is the issuing end of the ALU interface: it produces the operation codes the ALU consumes and samples the ALU's `zero` flag to resolve `beq`. It also handles memory wait states and counts retired instructions.

## Interface
- `IW`, 32: width of the retired-instruction counter.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  IR[31:26]; valid from DECODE onward.
- `funct`  in  6  IR[5:0]; valid from DECODE onward.
- `alu_zero`  in  1  ALU `zero` output.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `alu_control`  out  4  ALU operation code.
- `pc_write`  out  1  load PC.
- `ir_write`  out  1  load IR from memory data.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALU result.
- `mem_read`, `mem_write`  out  1 each  memory strobes.
- `reg_write`  out  1  register-file write enable.
- `reg_dst`  out  2  0 = rt, 1 = rd, 2 = $31.
- `mem_to_reg`  out  2  0 = ALU result, 1 = memory data, 2 = PC (link).
- `alu_src_a`  out  1  0 = PC, 1 = rs.
- `alu_src_b`  out  2  0 = rt, 1 = constant 4, 2 = sign-extended imm, 3 = zero-extended imm.
- `pc_src`  out  2  0 = ALU result, 1 = branch target, 2 = jump target, 3 = rs.
- `illegal`  out  1  one-cycle pulse on an undecodable instruction.
- `instr_count`  out  IW  retired instructions, wraps modulo 2^IW.

## Operation
- ALU codes: add 0000, addi 0001, lw 0010, sw 0011, sll 0100, and 0101, andi 0110, nor 0111, beq 1000, jal 1001, jr 1010, slt 1011.
- Decode: opcode 000000 with funct 100000 → add, 000000 → sll, 100100 → and, 100111 → nor, 101010 → slt, 001000 → jr. Opcode 001000 → addi, 001100 → andi, 100011 → lw, 101011 → sw, 000100 → beq, 000011 → jal. Anything else is illegal.
- States:
  - IDLE: reset state, all outputs 0, goes to FETCH.
  - FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_control=0000. Holds while mem_ready=0. On mem_ready=1, ir_write=1, pc_write=1, pc_src=0 (PC+4), go to DECODE.
  - DECODE: outputs 0. Goes to EXEC_R, EXEC_I, MEM_ADDR, BRANCH, JAL or JR; illegal pulses `illegal` and goes to FETCH.
  - EXEC_R: alu_src_a=1, alu_src_b=0, R-type code, then WB_R. WB_R: reg_write=1, reg_dst=1, mem_to_reg=0, ALU inputs and code held.
  - EXEC_I: alu_src_a=1, alu_src_b=2 for addi, 3 for andi, then WB_I. WB_I: reg_write=1, reg_dst=0, mem_to_reg=0, ALU inputs and code held.
  - MEM_ADDR: alu_src_a=1, alu_src_b=2, code 0010 (lw) or 0011 (sw). Goes to MEM_RD or MEM_WR.
  - MEM_RD: mem_read=1, iord=1, ALU held. Waits on mem_ready, then MEM_WB. MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1.
  - MEM_WR: mem_write=1, iord=1, ALU held. Waits on mem_ready.
  - BRANCH: alu_src_a=1, alu_src_b=0, code 1000, pc_src=1, pc_write=alu_zero. This is the only Mealy output.
  - JAL: code 1001, reg_write=1, reg_dst=2, mem_to_reg=2, pc_src=2, pc_write=1.
  - JR: code 1010, pc_src=3, pc_write=1.
- Terminal states are WB_R, WB_I, MEM_WB, MEM_WR (on mem_ready), BRANCH, JAL and JR. Each returns to FETCH and increments `instr_count`. Illegal instructions are not counted.

## Timing
- With no memory stalls: R-type/addi/andi take 4 cycles, lw 5, sw 4, beq/jal/jr 3.
- Each mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR adds one cycle. Strobes stay asserted throughout the wait.
- Outputs are decoded from the state register, except BRANCH `pc_write`.
- `rst_n` low at any time: state goes to IDLE, `instr_count` goes to 0, all outputs go to 0 immediately, even mid-access. First FETCH is one cycle after reset release.
- `instr_count` updates at the edge that leaves a terminal state. At the all-ones value it wraps to 0.

## Structure
- Shared package `mips_pkg`: ALU code constants, opcode/funct constants, state enum, reg_dst/mem_to_reg/alu_src_b/pc_src encodings.
- One sub-module, `mips_alu_decode`: combinational opcode/funct → ALU code, instruction class and illegal flag. The FSM and counter stay in the top module.

## Test plan
- add (000000/100000), mem_ready=1 → 4 cycles; alu_control 0000 in EXEC_R; reg_write=1 with reg_dst=1 in WB_R; instr_count 0→1.
- lw (100011), mem_ready low 2 cycles in MEM_RD → 7 cycles total; mem_read and iord stay 1 throughout; mem_to_reg=1 in MEM_WB.
- beq (000100), alu_zero=1 → pc_write=1 with pc_src=1 in BRANCH. Repeat with alu_zero=0 → pc_write=0. Both take 3 cycles.
- jal (000011) → reg_dst=2, mem_to_reg=2, pc_src=2, code 1001. jr (000000/001000) → pc_src=3, code 1010.
- opcode 111111 → `illegal` pulses for one cycle in DECODE, next state is FETCH, instr_count unchanged.
- rst_n low during MEM_WR with mem_ready=0 → all outputs 0 at once and instr_count=0. After release: IDLE, then FETCH. With IW=4, 16 retires → instr_count wraps to 0.
